rtc_update_sched: RTL
=====================

RTC_UPDATE_SCHED -- requirements
Module: rtc_update_sched

Interface
REQ-001 SHALL have parameter GUARD_CYCLES, default 4, guard-window width in clk_i cycles before a second rollover.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, idle cycles enforced after each issued update.
REQ-003 clk_i  input  1  clock.
REQ-004 rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  4  level requests: [0] clock set, [1] calibration, [2] timer, [3] alarm; held until acked.
REQ-006 ack_o  output  4  one-hot, one-cycle completion pulse per requester.
REQ-007 upd_o  output  4  one-hot, one-cycle update strobe to the clock core, same index map as req_i.
REQ-008 sec_cnt_i  input  16  current sub-second counter of the clock core.
REQ-009 calibre_i  input  16  current sub-second terminal count.
REQ-010 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, GUARD, ISSUE, ACK, SETTLE.
REQ-012 IDLE: if any req_i bit is set, grant one requester round-robin, starting the search at the bit after the last granted index; then go to GUARD if in guard window, else ISSUE.
REQ-013 Guard window SHALL be true when sec_cnt_i <= calibre_i and (calibre_i - sec_cnt_i) < GUARD_CYCLES, using 16-bit unsigned arithmetic; sec_cnt_i > calibre_i SHALL be out of window.
REQ-014 GUARD: stay until the window is false, then go to ISSUE.
REQ-015 ISSUE: assert upd_o[grant] for exactly one cycle, then go to ACK.
REQ-016 ACK: assert ack_o[grant] for exactly one cycle, then go to SETTLE, loading the settle counter with SETTLE_CYCLES.
REQ-017 SETTLE: decrement the counter each cycle and go to IDLE when it reaches 0; SETTLE_CYCLES=0 SHALL go straight to IDLE.
REQ-018 Latency: with req_i rising at cycle N in IDLE and outside the guard window, upd_o SHALL be high at N+1 and ack_o at N+2.
REQ-019 If req_i[grant] drops in GUARD, SHALL abort to IDLE with no upd_o and no ack_o, leaving the round-robin pointer unchanged.
REQ-020 Requests that arrive outside IDLE SHALL be held pending and arbitrated on the next IDLE.
REQ-021 The round-robin pointer SHALL update only on entry to ISSUE.
REQ-022 upd_o and ack_o SHALL be registered outputs, never asserted in the same cycle and never more than one bit set.

Reset
REQ-023 On reset: state IDLE, pointer 0 (index 0 has priority), settle counter 0, and ack_o, upd_o, busy_o all 0.
REQ-024 Reset asserted mid-operation SHALL abort any pending upd_o or ack_o immediately.

Configuration
REQ-025 With RTC_SCHED_GUARD_EN defined, SHALL behave per REQ-013/014.
REQ-026 Without RTC_SCHED_GUARD_EN, the guard window SHALL be constant false, GUARD SHALL be unreachable, and sec_cnt_i and calibre_i SHALL be unused.

Structure
REQ-027 SHALL place the state enum and requester index constants (REQ_CLOCK=0, REQ_CALIB=1, REQ_TIMER=2, REQ_ALARM=3) in shared package rtc_pkg.
REQ-028 SHALL implement the round-robin grant in sub-module rtc_rr_arbiter (4-bit request, pointer in, one-hot grant out).

Verification
REQ-029 req_i=4'b0001 with sec_cnt_i=100, calibre_i=0x7FFF at cycle N -> upd_o=0001 at N+1, ack_o=0001 at N+2, busy_o low at N+5.
REQ-030 req_i=4'b1111 held, each bit dropped after its ack -> grants in order 0,1,2,3, with 5 cycles between successive upd_o pulses.
REQ-031 GUARD_EN defined, calibre_i=0x7FFF, sec_cnt_i=0x7FFD, counter then wraps to 0 -> upd_o asserted only after sec_cnt_i=0.
REQ-032 req_i[2] dropped while in GUARD -> no upd_o, no ack_o, FSM back in IDLE, pointer unchanged.
REQ-033 rstn_i pulsed low in ISSUE state -> upd_o and ack_o 0, state IDLE, next grant goes to index 0.
REQ-034 GUARD_EN undefined, sec_cnt_i=calibre_i -> upd_o at N+1 regardless.

Source files
------------

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared state encoding, requester indices and helpers for the RTC update scheduler
package rtc_pkg;
  localparam int REQ_CLOCK = 0;
  localparam int REQ_CALIB = 1;
  localparam int REQ_TIMER = 2;
  localparam int REQ_ALARM = 3;
  typedef logic [2:0] rtc_state_t;
  localparam rtc_state_t ST_IDLE   = 3'd0;
  localparam rtc_state_t ST_GUARD  = 3'd1;
  localparam rtc_state_t ST_ISSUE  = 3'd2;
  localparam rtc_state_t ST_ACK    = 3'd3;
  localparam rtc_state_t ST_SETTLE = 3'd4;
  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction
endpackage

// File: rtl/rtc_rr_arbiter.sv
// rtc_rr_arbiter: 4-way round-robin grant, search starts at ptr_i
module rtc_rr_arbiter (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] gnt_o
);
  logic [7:0] rr, gg;
  logic [3:0] rot, low;
  // rotate so ptr_i lands on bit 0, take lowest set bit, rotate back
  always_comb begin
    rr = {req_i, req_i} >> ptr_i;
    rot = rr[3:0];
    low = rot & (~rot + 4'd1);
    gg = {low, low} << ptr_i;
    gnt_o = gg[7:4];
  end
endmodule

// File: rtl/rtc_update_sched.sv
// rtc_update_sched: serialises clock-core updates from four requesters, avoiding second rollover
// Optional guard window enabled by defining RTC_SCHED_GUARD_EN.
module rtc_update_sched
  import rtc_pkg::*;
#(
  parameter int GUARD_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [3:0]  req_i,
  output logic [3:0]  ack_o,
  output logic [3:0]  upd_o,
  input  logic [15:0] sec_cnt_i,
  input  logic [15:0] calibre_i,
  output logic        busy_o
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES + 1) : 1;
  rtc_state_t state;
  logic [1:0] ptr;
  logic [3:0] gnt_q, arb_gnt;
  logic [CW-1:0] cnt;
  logic in_guard;
`ifdef RTC_SCHED_GUARD_EN
  assign in_guard = (sec_cnt_i <= calibre_i) && ((calibre_i - sec_cnt_i) < 16'(GUARD_CYCLES));
`else
  logic unused_guard;
  assign unused_guard = ^{sec_cnt_i, calibre_i, 32'(GUARD_CYCLES)};
  assign in_guard = 1'b0;
`endif
  rtc_rr_arbiter u_arb (
    .req_i (req_i),
    .ptr_i (ptr),
    .gnt_o (arb_gnt)
  );
  assign busy_o = state != ST_IDLE;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= ST_IDLE;
      ptr   <= 2'd0;
      gnt_q <= 4'd0;
      cnt   <= '0;
      upd_o <= 4'd0;
      ack_o <= 4'd0;
    end else begin
      upd_o <= 4'd0;
      ack_o <= 4'd0;
      case (state)
        ST_IDLE: if (|req_i) begin
          gnt_q <= arb_gnt;
          if (in_guard) state <= ST_GUARD;
          else begin
            state <= ST_ISSUE;
            upd_o <= arb_gnt;
            ptr   <= oh2idx(arb_gnt) + 2'd1;
          end
        end
        ST_GUARD: if (~|(req_i & gnt_q)) state <= ST_IDLE;
        else if (!in_guard) begin
          state <= ST_ISSUE;
          upd_o <= gnt_q;
          ptr   <= oh2idx(gnt_q) + 2'd1;
        end
        ST_ISSUE: begin
          state <= ST_ACK;
          ack_o <= gnt_q;
        end
        ST_ACK: begin
          state <= SETTLE_CYCLES == 0 ? ST_IDLE : ST_SETTLE;
          cnt   <= CW'(SETTLE_CYCLES);
        end
        ST_SETTLE: begin
          cnt   <= cnt == '0 ? '0 : cnt - CW'(1);
          state <= cnt <= CW'(1) ? ST_IDLE : ST_SETTLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
